// File: rtl/ram_write_sequencer_if.sv
// Bundle between the register-RAM write sequencer, its two producers,
// the RAM write port and the read-port hazard queries.
interface ram_write_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  valid_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  ready_a;
    logic                  valid_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  ready_b;
    logic [ADDR_WIDTH-1:0] query_addr0;
    logic [ADDR_WIDTH-1:0] query_addr1;
    logic                  pending0;
    logic                  pending1;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic [CW-1:0]         fifo_count;

    modport master (
        output valid_a, addr_a, data_a, valid_b, addr_b, data_b, query_addr0, query_addr1,
        input  ready_a, ready_b, pending0, pending1, write_enable, write_address, data_out,
               busy, fifo_count
    );

    modport slave (
        input  valid_a, addr_a, data_a, valid_b, addr_b, data_b, query_addr0, query_addr1,
        output ready_a, ready_b, pending0, pending1, write_enable, write_address, data_out,
               busy, fifo_count
    );
endinterface

// File: rtl/ram_write_sequencer.sv
// Sole writer of the register RAM: zero-fills after reset, then merges two
// producers through an in-order FIFO into one registered write per cycle.
module ram_write_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_write_sequencer_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_SIZE);
    localparam logic [CW-1:0]         LIM_A    = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]         LIM_B    = CW'(FIFO_DEPTH - 2);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_b;
    logic [CW-1:0]         count;
    logic                  run;
    logic                  push_a;
    logic                  push_b;
    logic                  pop;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] wa_r;
    logic [DATA_WIDTH-1:0] wd_r;
    logic [FIFO_DEPTH-1:0] occ;
    logic [FIFO_DEPTH-1:0] hit0;
    logic [FIFO_DEPTH-1:0] hit1;

    assign run = (state == RUN);

    // Readiness looks only at the start-of-cycle count, so B's tighter limit
    // leaves room for a simultaneous A push without needing pop credit.
    assign bus.ready_a = run && (count <= LIM_A);
    assign bus.ready_b = run && (count <= LIM_B);

    assign push_a   = bus.valid_a && bus.ready_a && (bus.addr_a <= MAX_ADDR);
    assign push_b   = bus.valid_b && bus.ready_b && (bus.addr_b <= MAX_ADDR);
    assign pop      = run && (count != '0);
    assign wr_ptr_b = push_a ? wr_ptr + 1'b1 : wr_ptr;

    always_ff @(posedge clk) begin
        if (push_a) begin
            q_addr[wr_ptr] <= bus.addr_a;
            q_data[wr_ptr] <= bus.data_a;
        end
        if (push_b) begin
            q_addr[wr_ptr_b] <= bus.addr_b;
            q_data[wr_ptr_b] <= bus.data_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            we_r    <= 1'b0;
            wa_r    <= '0;
            wd_r    <= '0;
        end else if (state == CLEAR) begin
            we_r    <= 1'b1;
            wa_r    <= clr_cnt;
            wd_r    <= '0;
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == MAX_ADDR)
                state <= RUN;
        end else begin
            if (pop) begin
                we_r   <= 1'b1;
                wa_r   <= q_addr[rd_ptr];
                wd_r   <= q_data[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                we_r   <= 1'b0;
            end
            wr_ptr <= wr_ptr_b + PW'(push_b);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    // Slot i is live when its distance from the read pointer is below count.
    // The entry already on the write port has left the queue and is not flagged.
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
        assign occ[i]  = {1'b0, PW'(i) - rd_ptr} < count;
        assign hit0[i] = occ[i] && (q_addr[i] == bus.query_addr0);
        assign hit1[i] = occ[i] && (q_addr[i] == bus.query_addr1);
    end

    assign bus.pending0      = run ? |hit0 : 1'b1;
    assign bus.pending1      = run ? |hit1 : 1'b1;
    assign bus.write_enable  = we_r;
    assign bus.write_address = wa_r;
    assign bus.data_out      = wd_r;
    assign bus.busy          = !run;
    assign bus.fifo_count    = count;
endmodule

// File: tb/tb_ram_write_sequencer.sv
// Randomized bench for ram_write_sequencer against a queue-based model of
// the zero-fill, two-producer enqueue and one-per-cycle drain.
module tb_ram_write_sequencer;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MS = 16;
    localparam int FD = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_write_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) bus ();

    ram_write_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    ent_t          m_q[$];
    bit            m_run;
    int            m_fill;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    logic [DW-1:0] dut_ram [MS+1];
    int            ghost_seen;

    always @(posedge clk) begin
        if (bus.write_enable === 1'b1 && bus.write_address <= AW'(MS))
            dut_ram[bus.write_address] <= bus.data_out;
        if (bus.write_enable === 1'b1 && bus.data_out[DW-1:4] == 12'hDEA)
            ghost_seen <= ghost_seen + 1;
    end

    function automatic bit exp_ready_a();
        return m_run && (m_q.size() <= FD - 1);
    endfunction

    function automatic bit exp_ready_b();
        return m_run && (m_q.size() <= FD - 2);
    endfunction

    function automatic bit exp_pend(input logic [AW-1:0] q);
        if (!m_run) return 1'b1;
        foreach (m_q[i]) if (m_q[i].a == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_run  = 0;
        m_fill = 0;
        m_we   = 0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic drive(input bit va, input int aa, input int da,
                         input bit vb, input int ab, input int db);
        bus.valid_a = va; bus.addr_a = AW'(aa); bus.data_a = DW'(da);
        bus.valid_b = vb; bus.addr_b = AW'(ab); bus.data_b = DW'(db);
    endtask

    // Advance one clock: decide acceptance from pre-edge model state, then
    // apply the edge to the model. Returns at posedge + 1.
    task automatic tick();
        bit ra, rb, pop;
        ent_t head;
        ra  = exp_ready_a();
        rb  = exp_ready_b();
        pop = m_run && (m_q.size() > 0);
        if (pop) head = m_q[0];
        @(posedge clk);
        if (!m_run) begin
            m_we = 1; m_addr = AW'(m_fill); m_data = '0;
            if (m_fill == MS) m_run = 1;
            m_fill++;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_we = 1; m_addr = head.a; m_data = head.d;
            end else begin
                m_we = 0;
            end
            if (ra && bus.valid_a && bus.addr_a <= AW'(MS)) m_q.push_back({bus.addr_a, bus.data_a});
            if (rb && bus.valid_b && bus.addr_b <= AW'(MS)) m_q.push_back({bus.addr_b, bus.data_b});
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        bus.query_addr0 = '0; bus.query_addr1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.write_enable); end
        n_vec++; if (bus.write_address !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.write_address); end
        n_vec++; if (bus.data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        n_vec++; if (bus.fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        n_vec++; if ({bus.ready_a, bus.ready_b} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {bus.ready_a, bus.ready_b}); end
    endtask

    task automatic test_fill(input string tag);
        rst = 1'b0;
        for (int i = 0; i <= MS; i++) begin
            n_vec++; if ({bus.ready_a, bus.ready_b} !== 2'b00) begin n_err++; $display("FAIL %s_ready c%0d: got %b want 00", tag, i, {bus.ready_a, bus.ready_b}); end
            n_vec++; if ({bus.pending0, bus.pending1} !== 2'b11) begin n_err++; $display("FAIL %s_pend c%0d: got %b want 11", tag, i, {bus.pending0, bus.pending1}); end
            tick();
            n_vec++; if (bus.write_enable !== 1'b1 || bus.write_address !== AW'(i) || bus.data_out !== '0)
                begin n_err++; $display("FAIL %s_write c%0d: got we=%b a=%0d d=%h want we=1 a=%0d d=0", tag, i, bus.write_enable, bus.write_address, bus.data_out, i); end
            n_vec++; if (bus.busy !== (i < MS)) begin n_err++; $display("FAIL %s_busy c%0d: got %b want %b", tag, i, bus.busy, i < MS); end
        end
        tick();
        n_vec++; if (bus.write_enable !== 1'b0) begin n_err++; $display("FAIL %s_end_we: got %b want 0", tag, bus.write_enable); end
        n_vec++; if ({bus.ready_a, bus.ready_b} !== 2'b11) begin n_err++; $display("FAIL %s_end_ready: got %b want 11", tag, {bus.ready_a, bus.ready_b}); end
    endtask

    task automatic test_single_write();
        drive(1, 5, 'h1234, 0, 0, 0);
        bus.query_addr0 = AW'(5);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++; if (bus.pending0 !== 1'b1) begin n_err++; $display("FAIL single_pend_q: got %b want 1", bus.pending0); end
        n_vec++; if (bus.fifo_count !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.fifo_count); end
        n_vec++; if (bus.write_enable !== 1'b0) begin n_err++; $display("FAIL single_we_early: got %b want 0", bus.write_enable); end
        tick();
        n_vec++; if (bus.write_enable !== 1'b1 || bus.write_address !== AW'(5) || bus.data_out !== 16'h1234)
            begin n_err++; $display("FAIL single_write: got we=%b a=%0d d=%h want we=1 a=5 d=1234", bus.write_enable, bus.write_address, bus.data_out); end
        n_vec++; if (bus.pending0 !== 1'b0) begin n_err++; $display("FAIL single_pend_port: got %b want 0", bus.pending0); end
        tick();
        n_vec++; if (bus.write_enable !== 1'b0 || bus.data_out !== 16'h1234)
            begin n_err++; $display("FAIL single_after: got we=%b d=%h want we=0 d=1234", bus.write_enable, bus.data_out); end
    endtask

    task automatic test_same_edge();
        drive(1, 3, 'hAAAA, 1, 3, 'hBBBB);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.fifo_count !== 2) begin n_err++; $display("FAIL same_count: got %0d want 2", bus.fifo_count); end
        tick();
        n_vec++; if (bus.write_enable !== 1'b1 || bus.write_address !== AW'(3) || bus.data_out !== 16'hAAAA)
            begin n_err++; $display("FAIL same_first: got we=%b a=%0d d=%h want we=1 a=3 d=aaaa", bus.write_enable, bus.write_address, bus.data_out); end
        tick();
        n_vec++; if (bus.write_enable !== 1'b1 || bus.write_address !== AW'(3) || bus.data_out !== 16'hBBBB)
            begin n_err++; $display("FAIL same_second: got we=%b a=%0d d=%h want we=1 a=3 d=bbbb", bus.write_enable, bus.write_address, bus.data_out); end
        tick();
        n_vec++; if (dut_ram[3] !== 16'hBBBB) begin n_err++; $display("FAIL same_ram3: got %h want bbbb", dut_ram[3]); end
    endtask

    task automatic test_out_of_range();
        drive(1, 20, 'h5A5A, 0, 0, 0);
        bus.query_addr0 = AW'(20);
        #1;
        n_vec++; if (bus.ready_a !== 1'b1) begin n_err++; $display("FAIL oor_ready: got %b want 1", bus.ready_a); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++; if (bus.fifo_count !== 0) begin n_err++; $display("FAIL oor_count: got %0d want 0", bus.fifo_count); end
        n_vec++; if (bus.pending0 !== 1'b0) begin n_err++; $display("FAIL oor_pend: got %b want 0", bus.pending0); end
        tick();
        n_vec++; if (bus.write_enable !== 1'b0) begin n_err++; $display("FAIL oor_we: got %b want 0", bus.write_enable); end
    endtask

    // saturate: both producers hold valid every cycle with legal addresses.
    task automatic test_random(input string tag, input int cycles, input bit saturate);
        for (int c = 0; c < cycles + 6; c++) begin
            bit live;
            live = (c < cycles);
            drive(live && (saturate || $urandom_range(0, 2) != 0), saturate ? $urandom_range(0, MS) : $urandom_range(0, 20), $urandom,
                  live && (saturate || $urandom_range(0, 2) != 0), saturate ? $urandom_range(0, MS) : $urandom_range(0, 20), $urandom);
            if (m_q.size() > 0 && $urandom_range(0, 1) == 1) bus.query_addr0 = m_q[$urandom_range(0, m_q.size() - 1)].a;
            else bus.query_addr0 = AW'($urandom_range(0, 20));
            bus.query_addr1 = (m_q.size() > 0) ? m_q[m_q.size() - 1].a : AW'($urandom_range(0, 20));
            #1;
            n_vec++; if (bus.ready_a !== exp_ready_a() || bus.ready_b !== exp_ready_b())
                begin n_err++; $display("FAIL %s_ready c%0d: got %b%b want %b%b", tag, c, bus.ready_a, bus.ready_b, exp_ready_a(), exp_ready_b()); end
            n_vec++; if (bus.pending0 !== exp_pend(bus.query_addr0) || bus.pending1 !== exp_pend(bus.query_addr1))
                begin n_err++; $display("FAIL %s_pend c%0d: got %b%b want %b%b", tag, c, bus.pending0, bus.pending1, exp_pend(bus.query_addr0), exp_pend(bus.query_addr1)); end
            tick();
            n_vec++; if (bus.write_enable !== m_we || (m_we && (bus.write_address !== m_addr || bus.data_out !== m_data)))
                begin n_err++; $display("FAIL %s_write c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", tag, c, bus.write_enable, bus.write_address, bus.data_out, m_we, m_addr, m_data); end
            n_vec++; if (bus.fifo_count !== m_q.size() || bus.fifo_count > FD)
                begin n_err++; $display("FAIL %s_count c%0d: got %0d want %0d", tag, c, bus.fifo_count, m_q.size()); end
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 7, 'hDEA0, 1, 8, 'hDEA1);
        tick();
        drive(1, 9, 'hDEA2, 1, 10, 'hDEA3);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.fifo_count !== 3) begin n_err++; $display("FAIL mrst_pre_count: got %0d want 3", bus.fifo_count); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.write_enable !== 1'b0 || bus.write_address !== '0 || bus.data_out !== '0)
            begin n_err++; $display("FAIL mrst_async: got we=%b a=%0d d=%h want all 0", bus.write_enable, bus.write_address, bus.data_out); end
        n_vec++; if (bus.fifo_count !== 0 || bus.busy !== 1'b1)
            begin n_err++; $display("FAIL mrst_state: got count=%0d busy=%b want count=0 busy=1", bus.fifo_count, bus.busy); end
        model_reset();
        @(posedge clk);
        #1;
        ghost_seen = 0;
        test_fill("refill");
        repeat (6) tick();
        n_vec++; if (ghost_seen !== 0) begin n_err++; $display("FAIL mrst_ghost: got %0d flushed writes want 0", ghost_seen); end
    endtask

    initial begin
        ghost_seen = 0;
        test_reset();
        test_fill("fill");
        test_single_write();
        test_same_edge();
        test_random("b2b", 10, 1'b1);
        test_out_of_range();
        test_random("rand", 300, 1'b0);
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
